// File: rtl/axi_lite_line_mem_if.sv
// Cache-line AXI-Lite channel bundle between one cache master and the line memory responder.
interface axi_lite_line_mem_if;
   logic [31:0]  readAddr_addr;
   logic         readAddr_valid;
   logic         readAddr_ready;
   logic [127:0] readData_data;
   logic         readData_valid;
   logic         readData_ready;
   logic [31:0]  writeAddr_addr;
   logic         writeAddr_valid;
   logic         writeAddr_ready;
   logic [127:0] writeData_data;
   logic [15:0]  writeData_strb;
   logic         writeData_valid;
   logic         writeData_ready;
   logic [31:0]  writeResp_msg;
   logic         writeResp_valid;
   logic         writeResp_ready;

   modport master (
      output readAddr_addr, readAddr_valid, readData_ready,
      output writeAddr_addr, writeAddr_valid,
      output writeData_data, writeData_strb, writeData_valid, writeResp_ready,
      input  readAddr_ready, readData_data, readData_valid,
      input  writeAddr_ready, writeData_ready, writeResp_msg, writeResp_valid
   );

   modport slave (
      input  readAddr_addr, readAddr_valid, readData_ready,
      input  writeAddr_addr, writeAddr_valid,
      input  writeData_data, writeData_strb, writeData_valid, writeResp_ready,
      output readAddr_ready, readData_data, readData_valid,
      output writeAddr_ready, writeData_ready, writeResp_msg, writeResp_valid
   );
endinterface

// File: rtl/axi_lite_line_mem.sv
// Single-outstanding AXI-Lite responder serving 128-bit cache lines from a line-organised array,
// with programmable read and write-response latency.
module axi_lite_line_mem #(
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned READ_LAT  = 4,
   parameter int unsigned WRITE_LAT = 2
) (
   input logic                clk,
   input logic                rst,
   axi_lite_line_mem_if.slave bus
);
   localparam int unsigned LINE_W = 128;
   localparam int unsigned STRB_W = LINE_W / 8;
   localparam int unsigned IDX_W  = 28;
   localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W  = 4;
   localparam logic [31:0] RESP_OKAY   = 32'd0;
   localparam logic [31:0] RESP_SLVERR = 32'd2;

   typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_DATA, WR_WAIT, WR_RESP} state_t;

   state_t              state, next_state;
   logic [IDX_W-1:0]    idx, idx_d;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic                err, err_d;
   logic                ra_ready, ra_ready_d;
   logic                wa_ready, wa_ready_d;
   logic                wd_ready, wd_ready_d;
   logic [LINE_W-1:0]   rd_data, rd_data_d;
   logic                rd_valid, rd_valid_d;
   logic [31:0]         resp_msg, resp_msg_d;
   logic                resp_valid, resp_valid_d;

   logic [LINE_W-1:0]   mem [DEPTH];
   logic [MEM_AW-1:0]   mem_idx;
   logic                in_range;
   logic                rd_hs, wa_hs, wd_hs;
   logic                unused_addr_bits;

   assign unused_addr_bits = ^{bus.readAddr_addr[3:0], bus.writeAddr_addr[3:0]};

   assign mem_idx  = idx[MEM_AW-1:0];
   assign in_range = ({4'b0, idx} < 32'(DEPTH));
   assign rd_hs    = bus.readAddr_valid & ra_ready;
   // Read wins a same-cycle tie; the write address waits for the next IDLE.
   assign wa_hs    = bus.writeAddr_valid & wa_ready & ~bus.readAddr_valid;
   assign wd_hs    = bus.writeData_valid & wd_ready & (state == WR_DATA);

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (rd_hs) next_state = RD_WAIT;
                  else if (wa_hs) next_state = WR_DATA;
         RD_WAIT: if (cnt == CNT_W'(1)) next_state = RD_RESP;
         RD_RESP: if (bus.readData_ready) next_state = IDLE;
         WR_DATA: if (wd_hs) next_state = WR_WAIT;
         WR_WAIT: if (cnt == CNT_W'(1)) next_state = WR_RESP;
         WR_RESP: if (bus.writeResp_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Next values of all registered outputs and datapath state.
   always_comb begin
      idx_d        = idx;
      cnt_d        = cnt;
      err_d        = err;
      rd_data_d    = rd_data;
      rd_valid_d   = rd_valid;
      resp_msg_d   = resp_msg;
      resp_valid_d = resp_valid;
      ra_ready_d   = (next_state == IDLE);
      wa_ready_d   = (next_state == IDLE);
      wd_ready_d   = (next_state == WR_DATA);
      case (state)
         IDLE: begin
            if (rd_hs) begin
               idx_d = bus.readAddr_addr[31:4];
               cnt_d = CNT_W'(READ_LAT);
            end else if (wa_hs) begin
               idx_d = bus.writeAddr_addr[31:4];
            end
         end
         RD_WAIT: begin
            cnt_d = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               rd_data_d  = in_range ? mem[mem_idx] : '0;
               rd_valid_d = 1'b1;
            end
         end
         RD_RESP: if (bus.readData_ready) rd_valid_d = 1'b0;
         WR_DATA: begin
            if (wd_hs) begin
               cnt_d = CNT_W'(WRITE_LAT);
               err_d = ~in_range;
            end
         end
         WR_WAIT: begin
            cnt_d = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               resp_valid_d = 1'b1;
               resp_msg_d   = err ? RESP_SLVERR : RESP_OKAY;
            end
         end
         WR_RESP: begin
            if (bus.writeResp_ready) begin
               resp_valid_d = 1'b0;
               resp_msg_d   = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         idx        <= '0;
         cnt        <= '0;
         err        <= 1'b0;
         ra_ready   <= 1'b0;
         wa_ready   <= 1'b0;
         wd_ready   <= 1'b0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
         resp_msg   <= '0;
         resp_valid <= 1'b0;
      end else begin
         idx        <= idx_d;
         cnt        <= cnt_d;
         err        <= err_d;
         ra_ready   <= ra_ready_d;
         wa_ready   <= wa_ready_d;
         wd_ready   <= wd_ready_d;
         rd_data    <= rd_data_d;
         rd_valid   <= rd_valid_d;
         resp_msg   <= resp_msg_d;
         resp_valid <= resp_valid_d;
      end
   end

   // Byte-merge on the data commit edge; array contents survive reset.
   always_ff @(posedge clk) begin
      if (rst && wd_hs && in_range) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (bus.writeData_strb[b]) mem[mem_idx][8*b +: 8] <= bus.writeData_data[8*b +: 8];
         end
      end
   end

   assign bus.readAddr_ready  = ra_ready;
   assign bus.writeAddr_ready = wa_ready;
   assign bus.writeData_ready = wd_ready;
   assign bus.readData_data   = rd_data;
   assign bus.readData_valid  = rd_valid;
   assign bus.writeResp_msg   = resp_msg;
   assign bus.writeResp_valid = resp_valid;
endmodule

// File: tb/tb_axi_lite_line_mem.sv
// Directed bench for axi_lite_line_mem: reset, full/partial writes, backpressure, arbitration, range errors.
module tb_axi_lite_line_mem;
   localparam int unsigned DEPTH     = 1024;
   localparam int unsigned READ_LAT  = 4;
   localparam int unsigned WRITE_LAT = 2;
   localparam int          LIM       = 40;

   localparam logic [127:0] FULL    = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] ALL_AA  = {16{8'hAA}};
   localparam logic [127:0] ALL_55  = {16{8'h55}};
   localparam logic [127:0] PARTIAL = 128'hAAAAAAAAAAAAAAAA55555555AAAAAAAA;
   localparam logic [127:0] ONES    = {8{16'h1111}};
   localparam logic [127:0] LINE0   = {16{8'hC3}};

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   axi_lite_line_mem_if bus ();

   axi_lite_line_mem #(.DEPTH(DEPTH), .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic write_line(input string tag, input logic [31:0] a, input logic [127:0] d,
                             input logic [15:0] s, input logic [31:0] exp_msg);
      int n;
      bus.writeAddr_addr  = a;
      bus.writeAddr_valid = 1'b1;
      n = 0;
      while (!bus.writeAddr_ready && n < LIM) begin tick(); n++; end
      tick();
      bus.writeAddr_valid = 1'b0;
      bus.writeData_data  = d;
      bus.writeData_strb  = s;
      bus.writeData_valid = 1'b1;
      n = 0;
      while (!bus.writeData_ready && n < LIM) begin tick(); n++; end
      tick();
      bus.writeData_valid = 1'b0;
      bus.writeResp_ready = 1'b1;
      n = 0;
      while (!bus.writeResp_valid && n < LIM) begin tick(); n++; end
      check({tag, "_wlat"}, 128'(n), 128'(WRITE_LAT));
      check({tag, "_msg"}, 128'(bus.writeResp_msg), 128'(exp_msg));
      tick();
      bus.writeResp_ready = 1'b0;
   endtask

   task automatic read_line(input string tag, input logic [31:0] a, input logic [127:0] exp);
      int n;
      bus.readAddr_addr  = a;
      bus.readAddr_valid = 1'b1;
      n = 0;
      while (!bus.readAddr_ready && n < LIM) begin tick(); n++; end
      tick();
      bus.readAddr_valid = 1'b0;
      bus.readData_ready = 1'b1;
      n = 0;
      while (!bus.readData_valid && n < LIM) begin tick(); n++; end
      check({tag, "_rlat"}, 128'(n), 128'(READ_LAT));
      check({tag, "_data"}, bus.readData_data, exp);
      tick();
      bus.readData_ready = 1'b0;
   endtask

   initial begin
      int   n;
      logic ok;
      logic [127:0] held;

      bus.readAddr_addr   = '0;
      bus.readAddr_valid  = 1'b0;
      bus.readData_ready  = 1'b0;
      bus.writeAddr_addr  = '0;
      bus.writeAddr_valid = 1'b0;
      bus.writeData_data  = '0;
      bus.writeData_strb  = '0;
      bus.writeData_valid = 1'b0;
      bus.writeResp_ready = 1'b0;

      // Reset held with every master valid asserted
      rst = 1'b0;
      bus.readAddr_valid  = 1'b1;
      bus.writeAddr_valid = 1'b1;
      bus.writeData_valid = 1'b1;
      bus.readData_ready  = 1'b1;
      bus.writeResp_ready = 1'b1;
      repeat (3) tick();
      check("rst_ra_ready", 128'(bus.readAddr_ready), 128'(0));
      check("rst_wa_ready", 128'(bus.writeAddr_ready), 128'(0));
      check("rst_wd_ready", 128'(bus.writeData_ready), 128'(0));
      check("rst_rd_valid", 128'(bus.readData_valid), 128'(0));
      check("rst_wr_valid", 128'(bus.writeResp_valid), 128'(0));
      bus.readAddr_valid  = 1'b0;
      bus.writeAddr_valid = 1'b0;
      bus.writeData_valid = 1'b0;
      bus.readData_ready  = 1'b0;
      bus.writeResp_ready = 1'b0;
      rst = 1'b1;
      tick();
      check("rst_release_ra_ready", 128'(bus.readAddr_ready), 128'(1));

      // Full line write then read
      write_line("full", 32'h40, FULL, 16'hFFFF, 32'd0);
      read_line("full", 32'h40, FULL);

      // Partial strobe merge
      write_line("pre_aa", 32'h80, ALL_AA, 16'hFFFF, 32'd0);
      write_line("part", 32'h80, ALL_55, 16'h00F0, 32'd0);
      read_line("part", 32'h80, PARTIAL);

      // Zero strobe is legal and changes nothing
      write_line("strb0", 32'h40, ALL_55, 16'h0000, 32'd0);
      read_line("strb0", 32'h40, FULL);

      // Read data backpressure
      bus.readAddr_addr  = 32'h40;
      bus.readAddr_valid = 1'b1;
      tick();
      bus.readAddr_valid = 1'b0;
      n = 0;
      while (!bus.readData_valid && n < LIM) begin tick(); n++; end
      held = bus.readData_data;
      ok = 1'b1;
      bus.writeAddr_valid = 1'b1;
      bus.writeAddr_addr  = 32'h80;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (!bus.readData_valid || bus.readData_data !== held ||
             bus.readAddr_ready || bus.writeAddr_ready) ok = 1'b0;
      end
      bus.writeAddr_valid = 1'b0;
      check("rbp_stable", 128'(ok), 128'(1));
      check("rbp_data", held, FULL);
      bus.readData_ready = 1'b1;
      tick();
      bus.readData_ready = 1'b0;
      check("rbp_valid_drop", 128'(bus.readData_valid), 128'(0));
      check("rbp_ra_ready", 128'(bus.readAddr_ready), 128'(1));

      // Simultaneous read and write address
      bus.readAddr_addr   = 32'h80;
      bus.writeAddr_addr  = 32'h40;
      bus.writeData_data  = ALL_55;
      bus.writeData_strb  = 16'h0000;
      bus.readAddr_valid  = 1'b1;
      bus.writeAddr_valid = 1'b1;
      bus.readData_ready  = 1'b1;
      tick();
      bus.readAddr_valid = 1'b0;
      ok = 1'b1;
      n = 0;
      while (!bus.readData_valid && n < LIM) begin
         if (bus.writeAddr_ready || bus.writeData_ready) ok = 1'b0;
         tick();
         n++;
      end
      check("sim_wa_blocked", 128'(ok), 128'(1));
      check("sim_rdata", bus.readData_data, PARTIAL);
      tick();
      check("sim_rvalid_drop", 128'(bus.readData_valid), 128'(0));
      check("sim_wa_ready", 128'(bus.writeAddr_ready), 128'(1));
      tick();
      bus.writeAddr_valid = 1'b0;
      bus.readData_ready  = 1'b0;
      check("sim_wd_ready", 128'(bus.writeData_ready), 128'(1));
      bus.writeData_valid = 1'b1;
      tick();
      bus.writeData_valid = 1'b0;
      bus.writeResp_ready = 1'b1;
      n = 0;
      while (!bus.writeResp_valid && n < LIM) begin tick(); n++; end
      check("sim_msg", 128'(bus.writeResp_msg), 128'(0));
      tick();
      bus.writeResp_ready = 1'b0;

      // Write response backpressure
      bus.writeAddr_addr  = 32'h80;
      bus.writeAddr_valid = 1'b1;
      tick();
      bus.writeAddr_valid = 1'b0;
      bus.writeData_data  = ONES;
      bus.writeData_strb  = 16'hFFFF;
      bus.writeData_valid = 1'b1;
      tick();
      bus.writeData_valid = 1'b0;
      n = 0;
      while (!bus.writeResp_valid && n < LIM) begin tick(); n++; end
      check("wbp_wlat", 128'(n), 128'(WRITE_LAT));
      held = 128'(bus.writeResp_msg);
      ok = 1'b1;
      bus.readAddr_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (!bus.writeResp_valid || 128'(bus.writeResp_msg) !== held ||
             bus.readAddr_ready || bus.writeAddr_ready) ok = 1'b0;
      end
      bus.readAddr_valid = 1'b0;
      check("wbp_stable", 128'(ok), 128'(1));
      check("wbp_msg", held, 128'(0));
      bus.writeResp_ready = 1'b1;
      tick();
      bus.writeResp_ready = 1'b0;
      check("wbp_valid_drop", 128'(bus.writeResp_valid), 128'(0));
      check("wbp_wa_ready", 128'(bus.writeAddr_ready), 128'(1));
      read_line("wbp", 32'h80, ONES);

      // Out-of-range write and read leave the array alone
      write_line("line0", 32'h0, LINE0, 16'hFFFF, 32'd0);
      write_line("oor", 32'(DEPTH) << 4, {16{8'hFF}}, 16'hFFFF, 32'd2);
      read_line("oor", 32'(DEPTH) << 4, 128'h0);
      read_line("oor_alias", 32'h0, LINE0);

      // Reset during WR_WAIT suppresses the response
      bus.writeAddr_addr  = 32'h40;
      bus.writeAddr_valid = 1'b1;
      tick();
      bus.writeAddr_valid = 1'b0;
      bus.writeData_data  = ALL_AA;
      bus.writeData_strb  = 16'hFFFF;
      bus.writeData_valid = 1'b1;
      tick();
      bus.writeData_valid = 1'b0;
      check("rstw_pre_valid", 128'(bus.writeResp_valid), 128'(0));
      rst = 1'b0;
      tick();
      rst = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.writeResp_valid) ok = 1'b1;
      end
      check("rstw_no_resp", 128'(ok), 128'(0));
      check("rstw_idle", 128'(bus.readAddr_ready), 128'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
